// File: rtl/matmul_ctrl_pkg.sv
// Shared types and constants for the matmul job sequencer.
// State encoding, output FIFO depth and performance counter width live here.
package matmul_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_GAP,
        S_START,
        S_WAIT,
        S_DRAIN
    } ctrl_state_t;

    localparam int OUT_FIFO_DEPTH = 2;
    localparam int PERF_WIDTH     = 32;

    function automatic logic [PERF_WIDTH-1:0] perf_sat_inc(input logic [PERF_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/matmul_out_fifo.sv
// Purpose: 2-entry synchronous FIFO holding z words (data + last flag) ahead of the output stream.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: none internally; the producer throttles itself from count.
module matmul_out_fifo
    import matmul_ctrl_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    push,
    input  logic [WIDTH-1:0]                        push_data,
    input  logic                                    pop,
    output logic [WIDTH-1:0]                        head_data,
    output logic [$clog2(OUT_FIFO_DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam int CNT_W = $clog2(OUT_FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/matmul_job_ctrl.sv
// Purpose: streams x then y words into matmul_top, pulses start, waits for done, drains z to a ready/valid stream.
// Latency: first beat to job_done is 2*VECTOR_SIZE + 2 + WAIT cycles + VECTOR_SIZE+1 with no stalls.
// Backpressure: in_ready only while loading; out_ready throttles z reads through a 2-entry FIFO. MATMUL_CTRL_PERF_EN adds perf_cycles.
module matmul_job_ctrl
    import matmul_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int VECTOR_SIZE = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  job_done,
    output logic                  busy,
    output logic                  x_wr_en,
    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic                  y_wr_en,
    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic                  start,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout
`ifdef MATMUL_CTRL_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_cycles
`endif
);

    localparam int CW  = ADDR_WIDTH + 1;
    localparam int FCW = $clog2(OUT_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(VECTOR_SIZE - 1);
    localparam logic [CW-1:0] N_WORDS  = CW'(VECTOR_SIZE);

    ctrl_state_t     state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   rd_cnt;
    logic            wait_first;
    logic            in_flight;
    logic            in_flight_last;
    logic            beat;
    logic            beat_last;
    logic            issue;
    logic            pop;
    logic [FCW-1:0]  fifo_count;
    logic [FCW:0]    slots_used;
    logic [DATA_WIDTH:0] head;

    assign beat      = in_valid && in_ready;
    assign beat_last = beat && (cnt == LAST_IDX);

    assign out_valid = (fifo_count != '0);
    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_last  = out_valid && head[DATA_WIDTH];
    assign pop       = out_valid && out_ready;
    assign job_done  = pop && head[DATA_WIDTH];
    assign z_rd_addr = rd_cnt[ADDR_WIDTH-1:0];

    // A word leaving the FIFO this cycle frees its slot now, which sustains one word per cycle.
    assign slots_used = {1'b0, fifo_count} + {{FCW{1'b0}}, in_flight} - {{FCW{1'b0}}, pop};
    assign issue      = (state == S_DRAIN) && (rd_cnt < N_WORDS)
                        && (slots_used < (FCW+1)'(OUT_FIFO_DEPTH));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start     = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_LOAD_X;
            S_LOAD_X: begin
                in_ready = 1'b1;
                if (beat_last) state_nxt = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                in_ready = 1'b1;
                if (beat_last) state_nxt = S_GAP;
            end
            S_GAP:    state_nxt = S_START;
            S_START: begin
                start     = 1'b1;
                state_nxt = S_WAIT;
            end
            // The first WAIT cycle ignores a done level left over from the previous job.
            S_WAIT:   if (!wait_first && done) state_nxt = S_DRAIN;
            S_DRAIN:  if (job_done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            rd_cnt         <= '0;
            wait_first     <= 1'b0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            x_wr_en        <= 1'b0;
            x_wr_addr      <= '0;
            x_din          <= '0;
            y_wr_en        <= 1'b0;
            y_wr_addr      <= '0;
            y_din          <= '0;
        end else begin
            state   <= state_nxt;
            x_wr_en <= 1'b0;
            y_wr_en <= 1'b0;
            if (beat) begin
                cnt <= beat_last ? '0 : cnt + 1'b1;
                if (state == S_LOAD_X) begin
                    x_wr_en   <= 1'b1;
                    x_wr_addr <= cnt[ADDR_WIDTH-1:0];
                    x_din     <= in_data;
                end else begin
                    y_wr_en   <= 1'b1;
                    y_wr_addr <= cnt[ADDR_WIDTH-1:0];
                    y_din     <= in_data;
                end
            end
            wait_first     <= (state == S_START);
            in_flight      <= issue;
            in_flight_last <= issue && (rd_cnt == LAST_IDX);
            if (job_done) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    matmul_out_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_flight),
        .push_data ({in_flight_last, z_dout}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

`ifdef MATMUL_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] run_cnt;

    // run_cnt counts START plus every WAIT cycle already completed; the sampling cycle is added at latch time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt     <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == S_START) begin
                run_cnt <= PERF_WIDTH'(1);
            end else if (state == S_WAIT) begin
                run_cnt <= perf_sat_inc(run_cnt);
            end
            if (state == S_WAIT && state_nxt == S_DRAIN) begin
                perf_cycles <= perf_sat_inc(run_cnt);
            end
        end
    end
`endif

endmodule
